// File: rtl/axi4_rd_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin grant held from AR acceptance to RLAST,
// one outstanding burst, sticky burst-length mismatch flag.
module axi4_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // Requester 0
  input  logic [ADDR_W-1:0] S0_AXI_ARADDR,
  input  logic [7:0]        S0_AXI_ARLEN,
  input  logic [2:0]        S0_AXI_ARSIZE,
  input  logic [1:0]        S0_AXI_ARBURST,
  input  logic              S0_AXI_ARVALID,
  output logic              S0_AXI_ARREADY,
  output logic [DATA_W-1:0] S0_AXI_RDATA,
  output logic [1:0]        S0_AXI_RRESP,
  output logic              S0_AXI_RLAST,
  output logic              S0_AXI_RVALID,
  input  logic              S0_AXI_RREADY,
  // Requester 1
  input  logic [ADDR_W-1:0] S1_AXI_ARADDR,
  input  logic [7:0]        S1_AXI_ARLEN,
  input  logic [2:0]        S1_AXI_ARSIZE,
  input  logic [1:0]        S1_AXI_ARBURST,
  input  logic              S1_AXI_ARVALID,
  output logic              S1_AXI_ARREADY,
  output logic [DATA_W-1:0] S1_AXI_RDATA,
  output logic [1:0]        S1_AXI_RRESP,
  output logic              S1_AXI_RLAST,
  output logic              S1_AXI_RVALID,
  input  logic              S1_AXI_RREADY,
  // Shared master port
  output logic              M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic              M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic              LEN_ERR
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_next_q, rr_next_d;
  logic [7:0] beats_q, beats_d;
  logic       len_err_q, len_err_d;
  logic       ar_hs, r_hs;

  // RID is not needed: only one burst is ever outstanding.
  logic unused_rid;
  assign unused_rid = M_AXI_RID;

  assign LEN_ERR = len_err_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      rr_next_q <= 1'b0;
      beats_q   <= 8'd0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_next_q <= rr_next_d;
      beats_q   <= beats_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_next_d      = rr_next_q;
    beats_d        = beats_q;
    len_err_d      = len_err_q;
    ar_hs          = 1'b0;
    r_hs           = 1'b0;
    M_AXI_ARID     = 1'b0;
    M_AXI_ARADDR   = '0;
    M_AXI_ARLEN    = 8'd0;
    M_AXI_ARSIZE   = 3'd0;
    M_AXI_ARBURST  = 2'd0;
    M_AXI_ARVALID  = 1'b0;
    M_AXI_RREADY   = 1'b0;
    S0_AXI_ARREADY = 1'b0;
    S1_AXI_ARREADY = 1'b0;
    S0_AXI_RDATA   = '0;
    S0_AXI_RRESP   = 2'd0;
    S0_AXI_RLAST   = 1'b0;
    S0_AXI_RVALID  = 1'b0;
    S1_AXI_RDATA   = '0;
    S1_AXI_RRESP   = 2'd0;
    S1_AXI_RLAST   = 1'b0;
    S1_AXI_RVALID  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (S0_AXI_ARVALID || S1_AXI_ARVALID) begin
          state_d = StAddr;
          if (S0_AXI_ARVALID && S1_AXI_ARVALID) grant_d = rr_next_q;
          else                                  grant_d = S1_AXI_ARVALID;
        end
      end

      StAddr: begin
        M_AXI_ARID = grant_q;
        if (grant_q) begin
          M_AXI_ARADDR   = S1_AXI_ARADDR;
          M_AXI_ARLEN    = S1_AXI_ARLEN;
          M_AXI_ARSIZE   = S1_AXI_ARSIZE;
          M_AXI_ARBURST  = S1_AXI_ARBURST;
          M_AXI_ARVALID  = S1_AXI_ARVALID;
          S1_AXI_ARREADY = M_AXI_ARREADY;
        end else begin
          M_AXI_ARADDR   = S0_AXI_ARADDR;
          M_AXI_ARLEN    = S0_AXI_ARLEN;
          M_AXI_ARSIZE   = S0_AXI_ARSIZE;
          M_AXI_ARBURST  = S0_AXI_ARBURST;
          M_AXI_ARVALID  = S0_AXI_ARVALID;
          S0_AXI_ARREADY = M_AXI_ARREADY;
        end
        ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
        if (ar_hs) begin
          beats_d = M_AXI_ARLEN;
          state_d = StData;
        end
      end

      StData: begin
        if (grant_q) begin
          S1_AXI_RDATA  = M_AXI_RDATA;
          S1_AXI_RRESP  = M_AXI_RRESP;
          S1_AXI_RLAST  = M_AXI_RLAST;
          S1_AXI_RVALID = M_AXI_RVALID;
          M_AXI_RREADY  = S1_AXI_RREADY;
        end else begin
          S0_AXI_RDATA  = M_AXI_RDATA;
          S0_AXI_RRESP  = M_AXI_RRESP;
          S0_AXI_RLAST  = M_AXI_RLAST;
          S0_AXI_RVALID = M_AXI_RVALID;
          M_AXI_RREADY  = S0_AXI_RREADY;
        end
        r_hs = M_AXI_RVALID && M_AXI_RREADY;
        if (r_hs) begin
          // Saturate so an over-long burst keeps flagging instead of wrapping.
          if (beats_q != 8'd0) beats_d = beats_q - 8'd1;
          if (M_AXI_RLAST != (beats_q == 8'd0)) len_err_d = 1'b1;
          if (M_AXI_RLAST) begin
            state_d   = StIdle;
            rr_next_d = ~grant_q;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Randomized bench for axi4_rd_arbiter: bench-side requesters and slave, with a
// transaction-level reference model for grant order, timing, data routing and LEN_ERR.
module tb_axi4_rd_arbiter;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] s_araddr [2];
  logic [7:0]  s_arlen  [2];
  logic [2:0]  s_arsize [2];
  logic [1:0]  s_arburst[2];
  logic        s_arvalid[2];
  logic        s_arready[2];
  logic [31:0] s_rdata  [2];
  logic [1:0]  s_rresp  [2];
  logic        s_rlast  [2];
  logic        s_rvalid [2];
  logic        s_rready [2];
  logic        m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic        m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic        len_err;

  axi4_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(clk), .ARESET(arst),
    .S0_AXI_ARADDR(s_araddr[0]), .S0_AXI_ARLEN(s_arlen[0]), .S0_AXI_ARSIZE(s_arsize[0]),
    .S0_AXI_ARBURST(s_arburst[0]), .S0_AXI_ARVALID(s_arvalid[0]), .S0_AXI_ARREADY(s_arready[0]),
    .S0_AXI_RDATA(s_rdata[0]), .S0_AXI_RRESP(s_rresp[0]), .S0_AXI_RLAST(s_rlast[0]),
    .S0_AXI_RVALID(s_rvalid[0]), .S0_AXI_RREADY(s_rready[0]),
    .S1_AXI_ARADDR(s_araddr[1]), .S1_AXI_ARLEN(s_arlen[1]), .S1_AXI_ARSIZE(s_arsize[1]),
    .S1_AXI_ARBURST(s_arburst[1]), .S1_AXI_ARVALID(s_arvalid[1]), .S1_AXI_ARREADY(s_arready[1]),
    .S1_AXI_RDATA(s_rdata[1]), .S1_AXI_RRESP(s_rresp[1]), .S1_AXI_RLAST(s_rlast[1]),
    .S1_AXI_RVALID(s_rvalid[1]), .S1_AXI_RREADY(s_rready[1]),
    .M_AXI_ARID(m_arid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen),
    .M_AXI_ARSIZE(m_arsize), .M_AXI_ARBURST(m_arburst), .M_AXI_ARVALID(m_arvalid),
    .M_AXI_ARREADY(m_arready), .M_AXI_RID(m_rid), .M_AXI_RDATA(m_rdata),
    .M_AXI_RRESP(m_rresp), .M_AXI_RLAST(m_rlast), .M_AXI_RVALID(m_rvalid),
    .M_AXI_RREADY(m_rready), .LEN_ERR(len_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         cyc = 0;
  bit         busy, in_data, g;
  int         expect_at = -1;
  logic [1:0] dec_mask;
  int         last_done = 0;
  bit         last_grant = 1'b1;
  bit         exp_len_err, chk_reset;
  int         cur_len;

  // Requester stimulus
  bit          pend[2], rand_en[2], sc_valid[2];
  logic [31:0] sc_addr[2];
  logic [7:0]  sc_len[2];
  int          req_pct = 30, rready_pct = 100, max_len = 7;

  // Slave stimulus
  bit          sl_active, sl_rv, inc_data;
  int          sl_idx, sl_last_idx;
  int          ar_seen, ar_delay, ar_dmin, ar_dmax;
  int          rvalid_pct = 100, err_pct = 0, sc_err_idx = -1;
  logic [31:0] data_base;
  int          delivered;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic pick(input logic [1:0] m);
    if (m == 2'b11) return ~last_grant;
    return m[1];
  endfunction

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      if (!pend[r]) begin
        if (sc_valid[r]) begin
          pend[r] = 1'b1;
          s_araddr[r] = sc_addr[r];
          s_arlen[r] = sc_len[r];
          sc_valid[r] = 1'b0;
          s_arsize[r] = 3'($urandom_range(0, 7));
          s_arburst[r] = 2'($urandom_range(0, 3));
        end else if (rand_en[r] && $urandom_range(0, 99) < req_pct) begin
          pend[r] = 1'b1;
          s_araddr[r] = $urandom & 32'hffff_fffc;
          s_arlen[r] = 8'($urandom_range(0, max_len));
          s_arsize[r] = 3'($urandom_range(0, 7));
          s_arburst[r] = 2'($urandom_range(0, 3));
        end
      end
      s_arvalid[r] = pend[r];
      s_rready[r] = ($urandom_range(0, 99) < rready_pct);
    end
    m_arready = (ar_seen >= ar_delay);
    if (sl_active && !sl_rv && $urandom_range(0, 99) < rvalid_pct) begin
      sl_rv = 1'b1;
      m_rdata = inc_data ? data_base + 32'(sl_idx) : $urandom;
      m_rlast = (sl_idx == sl_last_idx);
      m_rresp = 2'($urandom_range(0, 3));
    end
    m_rvalid = sl_rv;
    m_rid = 1'($urandom_range(0, 1));
  endtask

  task automatic monitor();
    int og;
    if (chk_reset) begin
      check_eq("rst_arvalid", m_arvalid, 0);
      check_eq("rst_arid", m_arid, 0);
      check_eq("rst_araddr", m_araddr, 0);
      check_eq("rst_arlen", m_arlen, 0);
      check_eq("rst_rready", m_rready, 0);
      check_eq("rst_s_arready", {s_arready[1], s_arready[0]}, 0);
      check_eq("rst_s_rvalid", {s_rvalid[1], s_rvalid[0]}, 0);
      check_eq("rst_s_rlast", {s_rlast[1], s_rlast[0]}, 0);
      check_eq("rst_len_err", len_err, 0);
      chk_reset = 1'b0;
    end
    check_eq("len_err", len_err, exp_len_err);
    if (!busy) begin
      check_eq("arvalid_timing", m_arvalid, expect_at == cyc);
      check_eq("idle_rready", m_rready, 0);
      check_eq("idle_s_rvalid", {s_rvalid[1], s_rvalid[0]}, 0);
      if (m_arvalid) begin
        busy = 1'b1;
        in_data = 1'b0;
        g = pick(dec_mask);
        expect_at = -1;
      end else if (cyc > last_done && (s_arvalid[0] || s_arvalid[1])) begin
        expect_at = cyc + 1;
        dec_mask = {s_arvalid[1], s_arvalid[0]};
      end else begin
        expect_at = -1;
      end
    end
    og = g ? 0 : 1;
    if (busy && !in_data) begin
      check_eq("arvalid_hold", m_arvalid, 1);
      check_eq("arid", m_arid, g);
      check_eq("araddr", m_araddr, s_araddr[g]);
      check_eq("arlen", m_arlen, s_arlen[g]);
      check_eq("arsize", m_arsize, s_arsize[g]);
      check_eq("arburst", m_arburst, s_arburst[g]);
      check_eq("s_arready_gnt", s_arready[g], m_arready);
      check_eq("s_arready_other", s_arready[og], 0);
      check_eq("addr_rready", m_rready, 0);
      if (m_arready) begin
        pend[g] = 1'b0;
        in_data = 1'b1;
        cur_len = int'(s_arlen[g]);
        sl_active = 1'b1;
        sl_idx = 0;
        sl_rv = 1'b0;
        if (sc_err_idx >= 0) sl_last_idx = sc_err_idx;
        else if ($urandom_range(0, 99) < err_pct) begin
          sl_last_idx = $urandom_range(0, cur_len + 2);
          if (sl_last_idx == cur_len) sl_last_idx = cur_len + 1;
        end else sl_last_idx = cur_len;
        sc_err_idx = -1;
        ar_seen = 0;
        ar_delay = $urandom_range(ar_dmin, ar_dmax);
      end else begin
        ar_seen++;
      end
    end else if (busy && in_data) begin
      check_eq("data_arvalid", m_arvalid, 0);
      check_eq("data_araddr", m_araddr, 0);
      check_eq("data_s_arready", {s_arready[1], s_arready[0]}, 0);
      check_eq("rvalid_gnt", s_rvalid[g], m_rvalid);
      check_eq("rvalid_other", s_rvalid[og], 0);
      check_eq("rdata_other", s_rdata[og], 0);
      check_eq("rready_mirror", m_rready, s_rready[g]);
      if (m_rvalid && m_rready) begin
        check_eq("rdata", s_rdata[g], m_rdata);
        check_eq("rresp", s_rresp[g], m_rresp);
        check_eq("rlast", s_rlast[g], m_rlast);
        if (m_rlast ? (sl_idx != cur_len) : (sl_idx >= cur_len)) exp_len_err = 1'b1;
        delivered++;
        sl_rv = 1'b0;
        if (m_rlast) begin
          busy = 1'b0;
          in_data = 1'b0;
          sl_active = 1'b0;
          last_done = cyc;
          last_grant = g;
        end else begin
          sl_idx++;
        end
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    busy = 1'b0;
    in_data = 1'b0;
    sl_active = 1'b0;
    sl_rv = 1'b0;
    expect_at = -1;
    last_grant = 1'b1;
    exp_len_err = 1'b0;
    ar_seen = 0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0;
      s_arvalid[r] = 1'b0;
      s_rready[r] = 1'b0;
    end
    m_rvalid = 1'b0;
    m_arready = 1'b0;
    @(posedge clk);
    #1;
    last_done = cyc;
    cyc++;
    arst = 1'b0;
    chk_reset = 1'b1;
  endtask

  task automatic run_until_idle(input string tag, input int max_cyc);
    int n = 0;
    while ((busy || pend[0] || pend[1] || sc_valid[0] || sc_valid[1]) && n < max_cyc) begin
      cycle();
      n++;
    end
    check_eq(tag, n < max_cyc, 1);
  endtask

  task automatic script(input int r, input logic [31:0] addr, input logic [7:0] len);
    sc_valid[r] = 1'b1;
    sc_addr[r] = addr;
    sc_len[r] = len;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int r = 0; r < 2; r++) begin
      s_araddr[r] = '0; s_arlen[r] = '0; s_arsize[r] = '0; s_arburst[r] = '0;
      s_arvalid[r] = 1'b0; s_rready[r] = 1'b0;
    end
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0; m_rid = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single S0 read with known data
    inc_data = 1'b1; data_base = 32'h10;
    script(0, 32'h1000, 8'd3);
    run_until_idle("single_s0", 100);

    // Simultaneous requests right after reset: S0 then S1
    do_reset();
    script(0, 32'h2000, 8'd1);
    script(1, 32'h3000, 8'd1);
    run_until_idle("simultaneous", 100);

    // Back-pressure: slow ARREADY, random S1 RREADY
    inc_data = 1'b0;
    ar_dmin = 5; ar_dmax = 5; ar_delay = 5; ar_seen = 0;
    rready_pct = 50; rvalid_pct = 80;
    for (int i = 0; i < 6; i++) begin
      script(1, $urandom & 32'hffff_fff0, 8'($urandom_range(0, 7)));
      run_until_idle("backpressure", 300);
    end

    // Max then min burst length
    ar_dmin = 0; ar_dmax = 0; ar_delay = 0;
    rready_pct = 100; rvalid_pct = 100;
    script(0, 32'h4000, 8'd255);
    run_until_idle("len255", 400);
    script(0, 32'h5000, 8'd0);
    run_until_idle("len0", 50);

    // Early RLAST on beat 2, then good bursts keep LEN_ERR set
    sc_err_idx = 1;
    script(0, 32'h6000, 8'd3);
    run_until_idle("len_err_burst", 100);
    script(1, 32'h7000, 8'd2);
    run_until_idle("after_err_1", 100);
    script(0, 32'h7100, 8'd0);
    run_until_idle("after_err_2", 100);

    // Reset after the first beat of an 8-beat burst, then a fresh S1 read
    rvalid_pct = 50;
    d0 = delivered;
    script(0, 32'h8000, 8'd7);
    for (int n = 0; n < 100 && delivered == d0; n++) cycle();
    check_eq("mid_burst_beat", delivered > d0, 1);
    do_reset();
    cycle();
    script(1, 32'h9000, 8'd3);
    run_until_idle("after_reset_s1", 100);

    // Randomized mix with both requesters and occasional length errors
    rand_en[0] = 1'b1; rand_en[1] = 1'b1;
    req_pct = 40; max_len = 7; err_pct = 10;
    rready_pct = 70; rvalid_pct = 70; ar_dmin = 0; ar_dmax = 3;
    for (int i = 0; i < 3000; i++) cycle();
    rand_en[0] = 1'b0; rand_en[1] = 1'b0;
    run_until_idle("random_drain", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4_rd_arbiter.md
# axi4_rd_arbiter

Two-requester AXI4 read-channel arbiter that shares one AXI4 master read port (AR + R channels) between requesters S0 and S1. It sits between two read-side masters (VGA line fetch, CPU-side read path) and the single memory-facing AXI4 read port. It allows one outstanding burst at a time. Grant alternates round-robin and is held from address acceptance until the RLAST handshake. A beat counter checks the slave's burst length against the issued ARLEN.

## Interface
- ADDR_W, 32, address width on all AR channels
- DATA_W, 32, read data width on all R channels
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high; one clock (ACLK), no other clock domains
- S0_AXI_ARADDR / S1_AXI_ARADDR  in  ADDR_W  requester burst address
- S0_AXI_ARLEN / S1_AXI_ARLEN  in  8  beats minus 1
- S0_AXI_ARSIZE / S1_AXI_ARSIZE  in  3  beat size
- S0_AXI_ARBURST / S1_AXI_ARBURST  in  2  burst type
- S0_AXI_ARVALID / S1_AXI_ARVALID  in  1  address request
- S0_AXI_ARREADY / S1_AXI_ARREADY  out  1  address accepted
- S0_AXI_RDATA / S1_AXI_RDATA  out  DATA_W  read data
- S0_AXI_RRESP / S1_AXI_RRESP  out  2  read response
- S0_AXI_RLAST / S1_AXI_RLAST  out  1  last beat
- S0_AXI_RVALID / S1_AXI_RVALID  out  1  beat valid
- S0_AXI_RREADY / S1_AXI_RREADY  in  1  beat accept
- M_AXI_ARID  out  1  index of granted requester (0/1)
- M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST  out  ADDR_W/8/3/2  muxed from granted requester
- M_AXI_ARVALID  out  1; M_AXI_ARREADY  in  1
- M_AXI_RID  in  1 (ignored); M_AXI_RDATA  in  DATA_W; M_AXI_RRESP  in  2; M_AXI_RLAST  in  1; M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1
- LEN_ERR  out  1  sticky burst-length mismatch flag

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: `grant` (1b), `rr_next` (1b, requester favoured on a tie), `beats` (8b down-counter), `LEN_ERR`.
- IDLE:
  - No ARVALID -> stay in IDLE.
  - Exactly one ARVALID -> grant that requester and go to ADDR.
  - Both ARVALID -> grant `rr_next` and go to ADDR.
- ADDR:
  - Master AR outputs follow the granted requester combinationally; M_AXI_ARVALID = S{grant}_AXI_ARVALID; S{grant}_AXI_ARREADY = M_AXI_ARREADY.
  - The ungranted requester's ARREADY = 0.
  - On the AR handshake: `beats` <= granted ARLEN, go to DATA.
- DATA:
  - S{grant} R outputs = M_AXI_R* and M_AXI_RREADY = S{grant}_AXI_RREADY.
  - The ungranted requester's RVALID = 0; its RDATA/RRESP/RLAST = 0.
  - On each R handshake, `beats` decrements.
  - On an R handshake with M_AXI_RLAST = 1: go to IDLE and set `rr_next` <= ~grant.
- Outside ADDR, all M_AXI_AR* outputs = 0. Outside DATA, M_AXI_RREADY = 0 and both S RVALID = 0.
- LEN_ERR is set on an R handshake where RLAST = 1 and `beats` != 0, or where RLAST = 0 and `beats` == 0. It is cleared only by ARESET.
- The FSM still exits DATA only on the RLAST handshake; a missing RLAST hangs the grant by design.
- RRESP passes through unmodified; error responses do not affect arbitration.

## Timing
- Reset values: state = IDLE, grant = 0, rr_next = 0, beats = 0, LEN_ERR = 0. All M_AXI_AR* = 0, M_AXI_ARVALID = 0, M_AXI_RREADY = 0, all S ARREADY/RVALID/RLAST = 0.
- ARESET mid-burst: FSM returns to IDLE on the next edge. Any in-flight master burst is abandoned; the system resets the slave together with the arbiter.
- Arbitration latency: ARVALID sampled in IDLE at edge N -> M_AXI_ARVALID = 1 during cycle N+1.
- First R beat can be accepted in the cycle after the AR handshake.
- After the RLAST handshake there is one mandatory IDLE cycle before the next M_AXI_ARVALID.
- Back-to-back requests with both requesters continuously requesting: grants alternate S0, S1, S0, ...
- A requester must hold ARVALID and its address fields stable until ARREADY, per AXI. The arbiter never withdraws M_AXI_ARVALID once asserted.
- ARLEN = 0 (single beat): one R handshake with RLAST = 1 and `beats` = 0 -> no error.
- ARLEN = 255: `beats` loaded with 255 and counts down to 0 at the last beat; no wrap.

## Test plan
- Single S0 read: ARADDR = 0x1000, ARLEN = 3, slave returns 4 beats 0x10..0x13 -> S0 receives 4 beats with RLAST on the 4th; M_AXI_ARID = 0; LEN_ERR = 0; S1 RVALID never 1.
- Simultaneous requests after reset: S0 and S1 both raise ARVALID in the same cycle (ARLEN = 1 each) -> S0 served first, S1 next. The second M_AXI_ARVALID rises exactly 2 cycles after S0's RLAST handshake.
- Back-pressure: slave ARREADY delayed 5 cycles and S1 RREADY toggled randomly -> M_AXI_ARVALID stays high until accepted; M_AXI_RREADY mirrors S1 RREADY; no beat is lost or duplicated.
- Length error: ARLEN = 3, slave asserts RLAST on beat 2 -> LEN_ERR = 1 after that edge, FSM returns to IDLE, LEN_ERR stays 1 through later good bursts.
- Reset mid-burst: ARESET pulsed after beat 1 of an ARLEN = 7 burst -> next cycle all outputs at reset values; a fresh S1 request then completes normally with grant = 1.
- Max and min length: ARLEN = 255 followed by ARLEN = 0 -> 256 beats then 1 beat delivered, LEN_ERR = 0.
